// File: rtl/io_pkg.sv
// Shared constants for the board-input conditioning path and the input register stage.
package io_pkg;

    localparam int IO_PORT_W       = 32;
    localparam int IO_TICK_DIV     = 1000;
    localparam int IO_STABLE_TICKS = 8;
    localparam int IO_CNT_W        = 4;

    // What a debounce bit does on the current clock edge.
    typedef enum logic [1:0] {
        DB_AGREE  = 2'd0,
        DB_HOLD   = 2'd1,
        DB_COUNT  = 2'd2,
        DB_COMMIT = 2'd3
    } db_action_e;

    // Prescaler counter width; a divide-by-1 still needs one bit to exist.
    function automatic int presc_w(input int tick_div);
        return (tick_div > 1) ? $clog2(tick_div) : 1;
    endfunction

endpackage

// File: rtl/io_debounce_bit.sv
// One conditioned input bit: two-flop synchroniser, tick-based stability counter, debounced level.
import io_pkg::*;

module io_debounce_bit #(
    parameter int STABLE_TICKS = IO_STABLE_TICKS,
    parameter int CNT_W        = IO_CNT_W
) (
    input  logic io_clk,
    input  logic resetn,
    input  logic raw,
    input  logic tick,
    output logic deb,
    output logic upd
);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    db_action_e       act;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;

        if (sync2_q == deb_q) begin
            act = DB_AGREE;
        end else if (!tick) begin
            act = DB_HOLD;
        end else if (cnt_q == CNT_LAST) begin
            act = DB_COMMIT;
        end else begin
            act = DB_COUNT;
        end

        // Any return to agreement wipes the count, so a glitch never leaves a partial update.
        cnt_d = cnt_q;
        deb_d = deb_q;
        unique case (act)
            DB_AGREE:  cnt_d = '0;
            DB_HOLD:   cnt_d = cnt_q;
            DB_COUNT:  cnt_d = cnt_q + CNT_W'(1);
            DB_COMMIT: begin
                cnt_d = '0;
                deb_d = sync2_q;
            end
            default:   cnt_d = '0;
        endcase
    end

    always_ff @(posedge io_clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign deb = deb_q;
    assign upd = (act == DB_COMMIT);

endmodule

// File: rtl/io_input_debounce.sv
// Debounces WIDTH raw board inputs on a shared tick prescaler; feeds in_port0..2 of the input stage.
// Define IO_EDGE_LATCH_EN to build the sticky rising-edge flags; otherwise edge_flags reads 0.
import io_pkg::*;

module io_input_debounce #(
    parameter int WIDTH        = IO_PORT_W,
    parameter int TICK_DIV     = IO_TICK_DIV,
    parameter int STABLE_TICKS = IO_STABLE_TICKS,
    parameter int CNT_W        = IO_CNT_W
) (
    input  logic             io_clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] raw_in,
    input  logic [WIDTH-1:0] clr_edges,
    output logic [WIDTH-1:0] deb_out,
    output logic             changed,
    output logic [WIDTH-1:0] edge_flags
);

    localparam int PRE_W = presc_w(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic             tick;
    logic             changed_q, changed_d;
    logic [WIDTH-1:0] deb_vec;
    logic [WIDTH-1:0] upd_vec;

    always_comb begin
        tick      = (pre_q == PRE_LAST);
        pre_d     = tick ? '0 : pre_q + PRE_W'(1);
        changed_d = |upd_vec;
    end

    always_ff @(posedge io_clk or negedge resetn) begin
        if (!resetn) begin
            pre_q     <= '0;
            changed_q <= 1'b0;
        end else begin
            pre_q     <= pre_d;
            changed_q <= changed_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        io_debounce_bit #(
            .STABLE_TICKS (STABLE_TICKS),
            .CNT_W        (CNT_W)
        ) u_bit (
            .io_clk (io_clk),
            .resetn (resetn),
            .raw    (raw_in[i]),
            .tick   (tick),
            .deb    (deb_vec[i]),
            .upd    (upd_vec[i])
        );
    end

    assign deb_out = deb_vec;
    assign changed = changed_q;

`ifdef IO_EDGE_LATCH_EN
    logic [WIDTH-1:0] flags_q, flags_d;
    logic [WIDTH-1:0] rise;

    // An update on a bit currently at 0 can only be a 0->1 transition; set beats clear.
    always_comb begin
        rise    = upd_vec & ~deb_vec;
        flags_d = (flags_q & ~clr_edges) | rise;
    end

    always_ff @(posedge io_clk or negedge resetn) begin
        if (!resetn) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign edge_flags = flags_q;
`else
    logic unused_clr_edges;
    assign unused_clr_edges = ^clr_edges;
    assign edge_flags       = '0;
`endif

endmodule
